// File: rtl/ucore_pkg.sv
// Shared definitions for the ucore bus arbiter: FSM encoding, default widths,
// and the width of the grant index.
package ucore_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } ucore_state_e;

    // Default parameter values.
    localparam int DEF_NREQ    = 4;
    localparam int DEF_AW      = 32;
    localparam int DEF_DW      = 32;
    localparam int DEF_TIMEOUT = 255;

    // Grant index width (covers up to 8 requesters).
    localparam int GID_W = 3;

    // Timeout counter width (covers TIMEOUT up to 65535).
    localparam int TMO_W = 16;

endpackage

// File: rtl/ucore_rr_pick.sv
// Combinational round-robin picker: search starts one above the last grant
// and wraps, returning the first active request found.
module ucore_rr_pick
    import ucore_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]  req,
    input  logic [GID_W-1:0] last,
    output logic             found,
    output logic [GID_W-1:0] idx
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    int                cand;

    // Rotate so bit 0 is the highest-priority requester, then priority-encode.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        dbl   = {req, req} >> (int'(last) + 1);
        rot   = dbl[NREQ-1:0];
        for (int j = 0; j < NREQ; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                cand  = int'(last) + 1 + j;
                if (cand >= NREQ) begin
                    cand = cand - NREQ;
                end
                idx = GID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/ucore_bus_arbiter.sv
// Round-robin arbiter sharing one memory port among NREQ ucore requesters,
// one outstanding transaction at a time, with a response timeout.
//
// Handshake: a requester holds req_valid/addr/wdata/wen stable until it sees
// its req_ready bit; req_ready is a single-cycle pulse that coincides with
// mem_req_valid && mem_req_ready. Every accepted request later gets exactly one
// rsp_valid pulse (data, write ack, or timeout error) unless reset intervenes.
module ucore_bus_arbiter
    import ucore_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    input  logic [NREQ-1:0]   req_wen,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic              mem_wen,
    input  logic              mem_rsp_valid,
    input  logic [DW-1:0]     mem_rsp_rdata,
    output logic [GID_W-1:0]  grant_id
);

    ucore_state_e     state, state_nxt;
    logic [GID_W-1:0] last_grant;
    logic [GID_W-1:0] grant_q;
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    wdata_q;
    logic             wen_q;
    logic [TMO_W-1:0] tmo_cnt;

    logic             pick_found;
    logic [GID_W-1:0] pick_idx;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_wdata;
    logic             sel_wen;
    logic [NREQ-1:0]  grant_oh;

    ucore_rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req_valid),
        .last  (last_grant),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Mux out the picked requester's fields and decode the current grant.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wen   = 1'b0;
        grant_oh  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == GID_W'(i)) begin
                sel_addr  = req_addr[i*AW +: AW];
                sel_wdata = req_wdata[i*DW +: DW];
                sel_wen   = req_wen[i];
            end
            grant_oh[i] = (grant_q == GID_W'(i));
        end
    end

    // State register, captured request, grant history and timeout counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= GID_W'(NREQ - 1);
            grant_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wen_q      <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_found) begin
                last_grant <= pick_idx;
                grant_q    <= pick_idx;
                addr_q     <= sel_addr;
                wdata_q    <= sel_wdata;
                wen_q      <= sel_wen;
            end
            // Counter is held at zero through ISSUE so WAIT always starts at 0.
            if (state == WAIT) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    // Next-state and handshake/response outputs; a real response beats timeout.
    always_comb begin
        state_nxt     = state;
        mem_req_valid = 1'b0;
        req_ready     = '0;
        rsp_valid     = '0;
        rsp_rdata     = '0;
        rsp_err       = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    req_ready = grant_oh;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    rsp_valid = grant_oh;
                    rsp_rdata = mem_rsp_rdata;
                    state_nxt = IDLE;
                end else if (tmo_cnt == TMO_W'(TIMEOUT)) begin
                    rsp_valid = grant_oh;
                    rsp_err   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wen   = wen_q;
    assign grant_id  = grant_q;

endmodule

// File: tb/tb_ucore_bus_arbiter.sv
// Directed bench for ucore_bus_arbiter: single read, fairness, backpressure,
// timeout, response/timeout coincidence, stray responses and reset in WAIT.
module tb_ucore_bus_arbiter;

    localparam int NREQ    = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 10;

    // Clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_wen;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               rsp_err;
    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic               mem_wen;
    logic               mem_rsp_valid;
    logic [DW-1:0]      mem_rsp_rdata;
    logic [2:0]         grant_id;

    ucore_bus_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_wen       (req_wen),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wen       (mem_wen),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .grant_id      (grant_id)
    );

    // Scoreboard
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [2:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks: inputs change 2 time units after the edge, outputs are
    // sampled 1 time unit later, well away from the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic w);
        req_valid[i]           = 1'b1;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = d;
        req_wen[i]             = w;
    endtask

    task automatic wait_issue(input string tag);
        for (int c = 0; c < 20; c++) begin
            step();
            mem_rsp_valid = 1'b0;
            settle();
            if (mem_req_valid) break;
        end
        check({tag, "_issue"}, 64'(mem_req_valid), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mreqv"}, 64'(mem_req_valid), 64'd0);
        check({tag, "_maddr"}, 64'(mem_addr), 64'd0);
        check({tag, "_mwdata"}, 64'(mem_wdata), 64'd0);
        check({tag, "_mwen"}, 64'(mem_wen), 64'd0);
        check({tag, "_rdy"}, 64'(req_ready), 64'd0);
        check({tag, "_rspv"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rdata"}, 64'(rsp_rdata), 64'd0);
        check({tag, "_err"}, 64'(rsp_err), 64'd0);
        check({tag, "_gid"}, 64'(grant_id), 64'd0);
    endtask

    initial begin
        logic [2:0]      exp_g;
        logic [NREQ-1:0] oh;
        int              lat;

        reset         = 1'b1;
        req_valid     = '0;
        req_addr      = '0;
        req_wdata     = '0;
        req_wen       = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;

        // Reset state
        repeat (3) step();
        settle();
        check_all_zero("reset");
        reset = 1'b0;

        // Single read: requester 2 reads 0x100, response 3 cycles after acceptance
        step();
        set_req(2, 32'h100, 32'h0, 1'b0);
        mem_req_ready = 1'b1;
        settle();
        check("rd_n_mreqv", 64'(mem_req_valid), 64'd0);
        step();
        settle();
        check("rd_n1_mreqv", 64'(mem_req_valid), 64'd1);
        check("rd_n1_rdy", 64'(req_ready), 64'b0100);
        check("rd_n1_addr", 64'(mem_addr), 64'h100);
        check("rd_n1_gid", 64'(grant_id), 64'd2);
        check("rd_n1_wen", 64'(mem_wen), 64'd0);
        req_valid = '0;
        step();
        settle();
        check("rd_w0_rspv", 64'(rsp_valid), 64'd0);
        step();
        settle();
        check("rd_w1_rspv", 64'(rsp_valid), 64'd0);
        step();
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hCAFE;
        settle();
        check("rd_rspv", 64'(rsp_valid), 64'b0100);
        check("rd_rdata", 64'(rsp_rdata), 64'hCAFE);
        check("rd_err", 64'(rsp_err), 64'd0);
        step();
        mem_rsp_valid = 1'b0;
        settle();
        check("rd_idle_rspv", 64'(rsp_valid), 64'd0);
        check("rd_idle_rdata", 64'(rsp_rdata), 64'd0);

        // Fairness: all four requesters held valid for eight transactions
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 32'h1000 + 32'(i), 32'h0, 1'b0);
        mem_req_ready = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++) exp_q.push_back(3'(i));
        for (int k = 0; k < 8; k++) begin
            wait_issue("fair");
            exp_g = exp_q.pop_front();
            oh    = NREQ'(1) << exp_g;
            check("fair_gid", 64'(grant_id), 64'(exp_g));
            check("fair_rdy", 64'(req_ready), 64'(oh));
            check("fair_addr", 64'(mem_addr), 64'h1000 + 64'(exp_g));
            step();
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = 32'h10 + 32'(k);
            settle();
            check("fair_rspv", 64'(rsp_valid), 64'(oh));
            check("fair_rdata", 64'(rsp_rdata), 64'h10 + 64'(k));
        end

        // Backpressure: requester 1 writes with mem_req_ready low for 5 cycles
        req_valid     = '0;
        mem_req_ready = 1'b0;
        set_req(1, 32'h200, 32'h55AA, 1'b1);
        wait_issue("bp");
        for (int b = 0; b < 5; b++) begin
            if (b > 0) step();
            settle();
            check("bp_addr", 64'(mem_addr), 64'h200);
            check("bp_wen", 64'(mem_wen), 64'd1);
            check("bp_wdata", 64'(mem_wdata), 64'h55AA);
            check("bp_mreqv", 64'(mem_req_valid), 64'd1);
            check("bp_rdy_low", 64'(req_ready), 64'd0);
        end
        step();
        mem_req_ready = 1'b1;
        settle();
        check("bp_rdy", 64'(req_ready), 64'b0010);
        check("bp_gid", 64'(grant_id), 64'd1);
        step();
        req_valid     = '0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h0;
        settle();
        check("bp_ack_rspv", 64'(rsp_valid), 64'b0010);
        check("bp_ack_err", 64'(rsp_err), 64'd0);

        // Timeout: requester 3 reads, no response ever arrives
        set_req(3, 32'h300, 32'h0, 1'b0);
        wait_issue("tmo");
        check("tmo_rdy", 64'(req_ready), 64'b1000);
        step();
        req_valid     = '0;
        mem_rsp_rdata = 32'hDEAD;
        lat           = -1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) step();
            settle();
            if (rsp_valid != '0) begin
                lat = k;
                break;
            end
        end
        check("tmo_latency", 64'(lat), 64'(TIMEOUT));
        check("tmo_rspv", 64'(rsp_valid), 64'b1000);
        check("tmo_err", 64'(rsp_err), 64'd1);
        check("tmo_rdata", 64'(rsp_rdata), 64'd0);

        // Coincidence: response lands on the timeout cycle
        set_req(0, 32'h400, 32'h0, 1'b0);
        wait_issue("coin");
        check("coin_gid", 64'(grant_id), 64'd0);
        step();
        req_valid = '0;
        for (int k = 1; k < TIMEOUT; k++) step();
        settle();
        check("coin_pre_rspv", 64'(rsp_valid), 64'd0);
        step();
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hBEEF;
        settle();
        check("coin_rspv", 64'(rsp_valid), 64'b0001);
        check("coin_err", 64'(rsp_err), 64'd0);
        check("coin_rdata", 64'(rsp_rdata), 64'hBEEF);
        // Stray response while IDLE
        step();
        settle();
        check("stray_rspv", 64'(rsp_valid), 64'd0);
        check("stray_err", 64'(rsp_err), 64'd0);
        check("stray_rdata", 64'(rsp_rdata), 64'd0);
        step();
        settle();
        check("stray2_rspv", 64'(rsp_valid), 64'd0);
        check("stray2_mreqv", 64'(mem_req_valid), 64'd0);
        mem_rsp_valid = 1'b0;

        // Reset in WAIT: requester 2 accepted, then reset before any response
        set_req(2, 32'h500, 32'h77, 1'b1);
        wait_issue("rst");
        check("rst_gid", 64'(grant_id), 64'd2);
        step();
        req_valid = '0;
        step();
        reset = 1'b1;
        step();
        settle();
        check_all_zero("rstw");
        step();
        reset         = 1'b0;
        mem_rsp_valid = 1'b1;
        settle();
        check("rst_stray_rspv", 64'(rsp_valid), 64'd0);
        for (int i = 0; i < NREQ; i++) set_req(i, 32'h600 + 32'(i), 32'h0, 1'b0);
        wait_issue("rst_next");
        check("rst_next_gid", 64'(grant_id), 64'd0);
        check("rst_next_rdy", 64'(req_ready), 64'b0001);
        step();
        req_valid     = '0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h1234;
        settle();
        check("rst_next_rspv", 64'(rsp_valid), 64'b0001);
        check("rst_next_rdata", 64'(rsp_rdata), 64'h1234);
        step();
        mem_rsp_valid = 1'b0;

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
